// File: rtl/uart_ext_if.sv
// Host-side bus of uart_ext: runtime configuration, FIFO handshakes and status.
interface uart_ext_if #(
    parameter int DBIT      = 8,
    parameter int DVSR_BITS = 16
);
    logic [DVSR_BITS-1:0] dvsr;
    logic [1:0]           par_mode;
    logic                 rd_uart;
    logic                 wr_uart;
    logic [DBIT-1:0]      w_data;
    logic                 clr_err;
    logic [DBIT-1:0]      r_data;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 rx_empty;
    logic                 tx_full;
    logic                 overrun;

    modport master (
        output dvsr, par_mode, rd_uart, wr_uart, w_data, clr_err,
        input  r_data, r_perr, r_ferr, rx_empty, tx_full, overrun
    );

    modport slave (
        input  dvsr, par_mode, rd_uart, wr_uart, w_data, clr_err,
        output r_data, r_perr, r_ferr, rx_empty, tx_full, overrun
    );
endinterface

// File: rtl/uart_ext.sv
// Full-duplex 16x oversampled UART with runtime divisor/parity, per-word error
// flags, sticky overrun and start-bit glitch rejection.
module uart_ext_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] w_data,
    output logic [W-1:0] r_data,
    output logic         empty,
    output logic         full
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] w_ptr, r_ptr;
    logic          wr_en, rd_en;

    // A push into a full FIFO is only honoured when a pop frees the head slot.
    assign rd_en  = rd & ~empty;
    assign wr_en  = wr & (~full | rd_en);
    assign r_data = mem[r_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: storage is reset so the read port shows 0 after reset; big RAMs normally skip this.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            w_ptr <= '0;
            r_ptr <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (wr_en) mem[w_ptr] <= w_data;
            case ({wr_en, rd_en})
                2'b10: begin
                    w_ptr <= w_ptr + AW'(1);
                    empty <= 1'b0;
                    full  <= (w_ptr + AW'(1)) == r_ptr;
                end
                2'b01: begin
                    r_ptr <= r_ptr + AW'(1);
                    full  <= 1'b0;
                    empty <= (r_ptr + AW'(1)) == w_ptr;
                end
                2'b11: begin
                    w_ptr <= w_ptr + AW'(1);
                    r_ptr <= r_ptr + AW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

module uart_ext #(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
    parameter int DVSR_BITS = 16,
    parameter int FIFO_W    = 2
) (
    input  logic      clk,
    input  logic      reset,
    uart_ext_if.slave bus,
    input  logic      rx,
    output logic      tx
);
    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic par_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    logic [DVSR_BITS-1:0] tick_cnt, dvsr_q;
    logic                 tick;

    // A divisor change suppresses the tick and restarts the count.
    assign tick = (tick_cnt == bus.dvsr) && (bus.dvsr == dvsr_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            dvsr_q   <= '0;
        end else begin
            // NOTE: non-blocking so dvsr_q and tick_cnt both see pre-edge values.
            dvsr_q <= bus.dvsr;
            if (bus.dvsr != dvsr_q || tick) tick_cnt <= '0;
            else                            tick_cnt <= tick_cnt + DVSR_BITS'(1);
        end
    end

    logic rx_s1, rx_s2, rx_prev, rx_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end
    assign rx_fall = rx_prev & ~rx_s2;

    state_t          rx_state;
    logic [S_W-1:0]  rx_s;
    logic [N_W-1:0]  rx_n;
    logic [DBIT-1:0] rx_b;
    logic [1:0]      rx_pmode;
    logic            rx_perr, rx_wr;
    logic [DBIT+1:0] rx_word, rx_head;
    logic            rx_empty, rx_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
            rx_pmode <= '0;
            rx_perr  <= 1'b0;
            rx_wr    <= 1'b0;
            rx_word  <= '0;
        end else begin
            rx_wr <= 1'b0;
            case (rx_state)
                IDLE: if (rx_fall) begin
                    rx_state <= START;
                    rx_s     <= '0;
                    rx_pmode <= bus.par_mode;
                end
                START: if (tick) begin
                    if (rx_s == S_W'(7)) begin
                        rx_s     <= '0;
                        rx_n     <= '0;
                        rx_perr  <= 1'b0;
                        rx_state <= rx_s2 ? IDLE : DATA;
                    end else rx_s <= rx_s + S_W'(1);
                end
                DATA: if (tick) begin
                    if (rx_s == S_W'(15)) begin
                        rx_s <= '0;
                        rx_b <= {rx_s2, rx_b[DBIT-1:1]};
                        if (rx_n == N_W'(DBIT-1)) rx_state <= par_on(rx_pmode) ? PARITY : STOP;
                        else                      rx_n     <= rx_n + N_W'(1);
                    end else rx_s <= rx_s + S_W'(1);
                end
                PARITY: if (tick) begin
                    if (rx_s == S_W'(15)) begin
                        rx_s     <= '0;
                        rx_perr  <= (^rx_b) ^ rx_s2 ^ (rx_pmode == PAR_ODD);
                        rx_state <= STOP;
                    end else rx_s <= rx_s + S_W'(1);
                end
                STOP: if (tick) begin
                    if (rx_s == S_W'(SB_TICK-1)) begin
                        rx_wr    <= 1'b1;
                        rx_word  <= {~rx_s2, rx_perr, rx_b};
                        rx_state <= IDLE;
                    end else rx_s <= rx_s + S_W'(1);
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    uart_ext_fifo #(.W(DBIT+2), .AW(FIFO_W)) rx_fifo (
        .clk(clk), .reset(reset), .wr(rx_wr), .rd(bus.rd_uart), .w_data(rx_word),
        .r_data(rx_head), .empty(rx_empty), .full(rx_full)
    );

    logic overrun_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                   overrun_q <= 1'b0;
        else if (rx_wr && rx_full && !bus.rd_uart)    overrun_q <= 1'b1;
        else if (bus.clr_err)                         overrun_q <= 1'b0;
    end

    assign bus.r_data   = rx_head[DBIT-1:0];
    assign bus.r_perr   = rx_head[DBIT];
    assign bus.r_ferr   = rx_head[DBIT+1];
    assign bus.rx_empty = rx_empty;
    assign bus.overrun  = overrun_q;

    state_t          tx_state;
    logic [S_W-1:0]  tx_s;
    logic [N_W-1:0]  tx_n;
    logic [DBIT-1:0] tx_b, tx_head;
    logic            tx_par_en, tx_pbit, tx_q, tx_pop, tx_empty, tx_full;

    // The head word stays in the FIFO until its stop bit has been sent.
    assign tx_pop = (tx_state == STOP) && tick && (tx_s == S_W'(SB_TICK-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state  <= IDLE;
            tx_s      <= '0;
            tx_n      <= '0;
            tx_b      <= '0;
            tx_par_en <= 1'b0;
            tx_pbit   <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!tx_empty) begin
                        tx_state  <= START;
                        tx_s      <= '0;
                        tx_b      <= tx_head;
                        tx_par_en <= par_on(bus.par_mode);
                        tx_pbit   <= (^tx_head) ^ (bus.par_mode == PAR_ODD);
                        tx_q      <= 1'b0;
                    end
                end
                START: if (tick) begin
                    if (tx_s == S_W'(15)) begin
                        tx_s     <= '0;
                        tx_n     <= '0;
                        tx_q     <= tx_b[0];
                        tx_state <= DATA;
                    end else tx_s <= tx_s + S_W'(1);
                end
                DATA: if (tick) begin
                    if (tx_s == S_W'(15)) begin
                        tx_s <= '0;
                        if (tx_n == N_W'(DBIT-1)) begin
                            tx_state <= tx_par_en ? PARITY : STOP;
                            tx_q     <= tx_par_en ? tx_pbit : 1'b1;
                        end else begin
                            tx_n <= tx_n + N_W'(1);
                            tx_b <= tx_b >> 1;
                            tx_q <= tx_b[1];
                        end
                    end else tx_s <= tx_s + S_W'(1);
                end
                PARITY: if (tick) begin
                    if (tx_s == S_W'(15)) begin
                        tx_s     <= '0;
                        tx_q     <= 1'b1;
                        tx_state <= STOP;
                    end else tx_s <= tx_s + S_W'(1);
                end
                STOP: if (tick) begin
                    if (tx_s == S_W'(SB_TICK-1)) begin
                        tx_s     <= '0;
                        tx_state <= IDLE;
                    end else tx_s <= tx_s + S_W'(1);
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    uart_ext_fifo #(.W(DBIT), .AW(FIFO_W)) tx_fifo (
        .clk(clk), .reset(reset), .wr(bus.wr_uart), .rd(tx_pop), .w_data(bus.w_data),
        .r_data(tx_head), .empty(tx_empty), .full(tx_full)
    );

    assign bus.tx_full = tx_full;
    assign tx          = tx_q;
endmodule

// File: tb/tb_uart_ext.sv
// Directed self-checking bench for uart_ext at dvsr=3 (one bit = 64 clocks).
module tb_uart_ext;
    localparam int BIT_CLKS = 64;

    logic clk = 1'b0;
    logic reset;
    logic rx_drv;
    logic loopback;
    logic rx_pin;
    logic tx_pin;
    int   tests  = 0;
    int   failed = 0;
    int   len;
    int   k;

    uart_ext_if #(.DBIT(8), .DVSR_BITS(16)) bus ();

    uart_ext #(.DBIT(8), .SB_TICK(16), .DVSR_BITS(16), .FIFO_W(2)) dut (
        .clk(clk), .reset(reset), .bus(bus), .rx(rx_pin), .tx(tx_pin)
    );

    assign rx_pin = loopback ? tx_pin : rx_drv;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [7:0] d);
        @(negedge clk);
        bus.w_data  = d;
        bus.wr_uart = 1'b1;
        @(negedge clk);
        bus.wr_uart = 1'b0;
    endtask

    task automatic host_pop();
        @(negedge clk);
        bus.rd_uart = 1'b1;
        @(negedge clk);
        bus.rd_uart = 1'b0;
    endtask

    task automatic rx_bit(input logic b);
        rx_drv = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic par_en, input logic pbit, input logic stop);
        @(negedge clk);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(d[i]);
        if (par_en) rx_bit(pbit);
        rx_bit(stop);
        rx_bit(1'b1);
    endtask

    // Number of whole clocks tx holds the given level, capped at 300.
    task automatic run_len(input logic level, output int n);
        n = 0;
        while (tx_pin === level && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rx(input string tag, input int limit);
        int j = 0;
        while (bus.rx_empty === 1'b1 && j < limit) begin
            @(negedge clk);
            j++;
        end
        check(tag, bus.rx_empty, 1'b0);
    endtask

    initial begin
        reset        = 1'b0;
        rx_drv       = 1'b1;
        loopback     = 1'b0;
        bus.dvsr     = 16'd3;
        bus.par_mode = 2'b00;
        bus.rd_uart  = 1'b0;
        bus.wr_uart  = 1'b0;
        bus.w_data   = 8'h00;
        bus.clr_err  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx", tx_pin, 1'b1);
        check("rst_tx_full", bus.tx_full, 1'b0);
        check("rst_rx_empty", bus.rx_empty, 1'b1);
        check("rst_overrun", bus.overrun, 1'b0);
        check("rst_r_data", bus.r_data, 8'h00);
        check("rst_r_perr", bus.r_perr, 1'b0);
        check("rst_r_ferr", bus.r_ferr, 1'b0);
        reset = 1'b1;

        // Reset in the middle of a transmission of 0x00.
        host_write(8'h00);
        repeat (150) @(negedge clk);
        check("tx_busy_low", tx_pin, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_tx", tx_pin, 1'b1);
        check("async_rst_tx_full", bus.tx_full, 1'b0);
        check("async_rst_rx_empty", bus.rx_empty, 1'b1);
        check("async_rst_overrun", bus.overrun, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (300) @(negedge clk);
        check("idle_after_rst_tx", tx_pin, 1'b1);
        check("idle_after_rst_rx_empty", bus.rx_empty, 1'b1);

        // 0xA5 waveform: runs after start are 1,0,1,00,1,0 then 1 (bit7+stop+idle).
        host_write(8'hA5);
        k = 0;
        while (tx_pin !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("a5_start_seen", tx_pin, 1'b0);
        run_len(1'b0, len);
        check("a5_start_len", (len >= 61 && len <= 64), 1'b1);
        run_len(1'b1, len); check("a5_b0", len, 64);
        run_len(1'b0, len); check("a5_b1", len, 64);
        run_len(1'b1, len); check("a5_b2", len, 64);
        run_len(1'b0, len); check("a5_b34", len, 128);
        run_len(1'b1, len); check("a5_b5", len, 64);
        run_len(1'b0, len); check("a5_b6", len, 64);
        run_len(1'b1, len); check("a5_b7_stop_idle", len, 300);
        check("a5_rx_untouched", bus.rx_empty, 1'b1);

        // Loopback with odd parity; a mid-frame par_mode change must not matter.
        loopback     = 1'b1;
        bus.par_mode = 2'b10;
        host_write(8'h3C);
        repeat (200) @(negedge clk);
        bus.par_mode = 2'b00;
        wait_rx("lb_arrive", 1500);
        check("lb_data", bus.r_data, 8'h3C);
        check("lb_perr", bus.r_perr, 1'b0);
        check("lb_ferr", bus.r_ferr, 1'b0);
        host_pop();
        check("lb_popped", bus.rx_empty, 1'b1);
        repeat (100) @(negedge clk);
        loopback = 1'b0;

        // 0x55 with even parity expected 0 but sent 1, and stop bit 0.
        bus.par_mode = 2'b01;
        send_rx(8'h55, 1'b1, 1'b1, 1'b0);
        check("err_data", bus.r_data, 8'h55);
        check("err_perr", bus.r_perr, 1'b1);
        check("err_ferr", bus.r_ferr, 1'b1);
        host_pop();
        check("err_popped", bus.rx_empty, 1'b1);

        // Start-bit glitch of about 3 ticks.
        bus.par_mode = 2'b00;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (12) @(negedge clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_rejected", bus.rx_empty, 1'b1);

        // Five frames into a four-deep receive FIFO.
        send_rx(8'h11, 1'b0, 1'b0, 1'b1);
        send_rx(8'h22, 1'b0, 1'b0, 1'b1);
        send_rx(8'h33, 1'b0, 1'b0, 1'b1);
        send_rx(8'h44, 1'b0, 1'b0, 1'b1);
        check("ovr_not_yet", bus.overrun, 1'b0);
        send_rx(8'h55, 1'b0, 1'b0, 1'b1);
        check("ovr_set", bus.overrun, 1'b1);
        check("ovr_head0", bus.r_data, 8'h11);
        host_pop();
        check("ovr_head1", bus.r_data, 8'h22);
        host_pop();
        check("ovr_head2", bus.r_data, 8'h33);
        host_pop();
        check("ovr_head3", bus.r_data, 8'h44);
        host_pop();
        check("ovr_drained", bus.rx_empty, 1'b1);
        check("ovr_sticky", bus.overrun, 1'b1);
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        check("ovr_cleared", bus.overrun, 1'b0);

        // Five back-to-back writes into the four-deep transmit FIFO, looped back.
        loopback = 1'b1;
        @(negedge clk);
        bus.wr_uart = 1'b1;
        bus.w_data  = 8'hA1;
        @(negedge clk);
        check("txf_after1", bus.tx_full, 1'b0);
        bus.w_data = 8'hA2;
        @(negedge clk);
        check("txf_after2", bus.tx_full, 1'b0);
        bus.w_data = 8'hA3;
        @(negedge clk);
        check("txf_after3", bus.tx_full, 1'b0);
        bus.w_data = 8'hA4;
        @(negedge clk);
        check("txf_after4", bus.tx_full, 1'b1);
        bus.w_data = 8'hA5;
        @(negedge clk);
        check("txf_after5", bus.tx_full, 1'b1);
        bus.wr_uart = 1'b0;
        repeat (3200) @(negedge clk);
        check("txf_drained", bus.tx_full, 1'b0);
        check("txf_no_overrun", bus.overrun, 1'b0);
        check("txf_rx0", bus.r_data, 8'hA1);
        host_pop();
        check("txf_rx1", bus.r_data, 8'hA2);
        host_pop();
        check("txf_rx2", bus.r_data, 8'hA3);
        host_pop();
        check("txf_rx3", bus.r_data, 8'hA4);
        host_pop();
        check("txf_fifth_dropped", bus.rx_empty, 1'b1);
        loopback = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_ext.md
Name: uart_ext

Overview:
- Second-generation UART: full-duplex, 16x oversampled receiver and transmitter, each with its own FIFO.
- Adds over the first generation: runtime baud divisor, runtime parity mode (none/even/odd), per-word parity and framing error flags stored alongside the data, sticky receive overrun flag, and start-bit glitch rejection.
- Sits between the system bus/register logic and the serial pins. Self-contained: the baud tick generator, both FSMs and both FIFOs are internal.

Parameters:
- DBIT, 8, data bits per frame
- SB_TICK, 16, ticks for stop bits (16/24/32 for 1/1.5/2 stop bits)
- DVSR_BITS, 16, width of the runtime divisor port
- FIFO_W, 2, FIFO address width; depth is 2^FIFO_W words per direction

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- dvsr  in  DVSR_BITS  baud divisor; one tick every dvsr+1 clocks
- par_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- rd_uart  in  1  pop one receive FIFO word
- wr_uart  in  1  push w_data into the transmit FIFO
- w_data  in  DBIT  transmit data
- clr_err  in  1  clears overrun
- rx  in  1  serial input (asynchronous)
- r_data  out  DBIT  receive FIFO head data
- r_perr  out  1  parity error of the head word
- r_ferr  out  1  framing error of the head word
- rx_empty  out  1  receive FIFO empty
- tx_full  out  1  transmit FIFO full
- overrun  out  1  sticky: a frame was dropped because the receive FIFO was full
- tx  out  1  serial output

Behaviour:
- **Reset (reset=0, asynchronous):**
  - tx=1, tx_full=0, rx_empty=1, overrun=0.
  - r_data=0, r_perr=0, r_ferr=0; all storage is cleared to 0.
  - Both FSMs go to IDLE and the tick counter goes to 0.
  - The rx synchroniser flops reset to 1.
  - Reset mid-frame aborts the frame with no FIFO write or pop.
- **Tick generator:**
  - Counter runs 0..dvsr; tick is a one-cycle pulse when count==dvsr, then the counter returns to 0.
  - dvsr=0 gives a tick every clock.
  - A change of dvsr restarts the counter at 0 on the next cycle.
- **rx input:** passes through a 2-flop synchroniser before use; sampling latency is 2 clocks.
- **Frame mode:** par_mode is latched at the start of each frame (rx on start-bit detect, tx on leaving IDLE). Changes mid-frame do not affect the frame in flight.
- **RX FSM (IDLE, START, DATA, PARITY, STOP):**
  - IDLE→START on a synchronised falling rx; reset the tick count.
  - START: after 7 ticks, sample rx. rx=0 → DATA. rx=1 → IDLE as a glitch, with no write.
  - DATA: sample every 16 ticks, LSB first, DBIT bits.
  - DATA→PARITY if parity is enabled, else →STOP.
  - PARITY: sample after 16 ticks. perr = (XOR of data) XOR sample XOR (par_mode==odd).
  - STOP: after SB_TICK ticks, sample rx. ferr = ~sample. Write {ferr, perr, data} to the receive FIFO, then →IDLE.
  - With parity disabled, perr is written as 0.
- **Overrun:**
  - Occurs when the frame completes while the receive FIFO is full (and rd_uart is not asserted that cycle).
  - The word is discarded and overrun is set.
  - overrun clears only on clr_err. If clr_err coincides with a new overrun, set wins.
- **TX FSM (IDLE, START, DATA, PARITY, STOP):**
  - Leaves IDLE when the transmit FIFO is not empty; latches the head word.
  - Drives start 0 for 16 ticks, then DBIT data bits LSB first at 16 ticks each.
  - If enabled, drives the parity bit for 16 ticks: even → XOR of data; odd → its complement.
  - Drives stop 1 for SB_TICK ticks.
  - At the end of stop: pop the FIFO, then →IDLE. Back-to-back frames have no idle gap beyond one clock.
  - tx is registered.
- **FIFOs (each 2^FIFO_W deep; receive word width DBIT+2):**
  - Read data is the head entry, combinational from storage.
  - Push when full: ignored (wr_uart lost, no flag).
  - Pop when empty: ignored.
  - Push+pop when full: both occur, and full stays asserted.
  - Push+pop when empty: push only.
  - Pointers wrap modulo 2^FIFO_W.
  - Flags are registered and update in the same cycle as the pointer change.

Test Plan:
- Reset during an active transmission → tx=1 within the same cycle; all outputs at their reset values. After release, with an empty transmit FIFO, tx stays 1.
- dvsr=3, par_mode=00: write 0xA5 → tx line shows start 0, then 1,0,1,0,0,1,0,1, then stop 1. Each bit lasts 64 clocks; frame is 640 clocks.
- Loopback tx→rx, dvsr=3, par_mode=10: send 0x3C → rx_empty falls, r_data=0x3C, r_perr=0, r_ferr=0. rd_uart → rx_empty=1.
- Drive rx with 0x55, even parity, but a wrong parity bit (1) and stop bit 0 → r_data=0x55, r_perr=1, r_ferr=1.
- Drive rx low for 3 ticks only → no FIFO write; rx_empty stays 1.
- FIFO_W=2: receive 5 frames without reading → first 4 stored in order, 5th dropped, overrun=1. clr_err → overrun=0. Write 5 words into the transmit FIFO → tx_full=1 after the 4th is accepted (minus any pop in progress); the 5th is ignored.
